// File: rtl/downsampler_nx.sv
// Raster downsampler by FACTOR per axis (decimate or box average) with an output FWFT FIFO.
// Define DOWNSAMPLER_AVG_EN to compile in average mode; otherwise the block always decimates.
module downsampler_nx #(
  parameter int DATA_WIDTH   = 8,
  parameter int FACTOR       = 4,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int OUT_DEPTH    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valid,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic                         mode,
  input  logic                         ready_out,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         validout,
  output logic                         frame_start_out,
  output logic                         blankingregion,
  output logic                         overflow,
  output logic [$clog2(OUT_DEPTH):0]   fifo_count
);

  localparam int LOG2F = $clog2(FACTOR);
  localparam int CW    = $clog2(LINE_WIDTH);
  localparam int RW    = $clog2(FRAME_HEIGHT);
  localparam int AW    = $clog2(OUT_DEPTH);
  localparam int CNTW  = AW + 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [LOG2F-1:0] PH_LAST  = '1;
  localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(OUT_DEPTH);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  mode_q;
  logic                  mode_eff;
  logic                  first_px;
  logic                  blk00;
  logic [LOG2F-1:0]      col_ph, row_ph;

  logic                  vld_p0_q, vld_p0_d;
  logic [DATA_WIDTH-1:0] res_p0_q, res_p0_d;
  logic                  fs_p0_q;

  assign first_px = (col_q == '0) && (row_q == '0);
  assign col_ph   = col_q[LOG2F-1:0];
  assign row_ph   = row_q[LOG2F-1:0];
  assign blk00    = ((col_q >> LOG2F) == '0) && ((row_q >> LOG2F) == '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

`ifdef DOWNSAMPLER_AVG_EN
  localparam int NBLK = LINE_WIDTH / FACTOR;
  localparam int JW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int HW   = DATA_WIDTH + LOG2F;
  localparam int SW   = DATA_WIDTH + 2 * LOG2F;

  // Divide by FACTOR^2 is a plain shift; the fraction is discarded.
  function automatic logic [DATA_WIDTH-1:0] avg_trunc(input logic [SW-1:0] s);
    logic [SW-1:0] sh;
    sh = s >> (2 * LOG2F);
    return sh[DATA_WIDTH-1:0];
  endfunction

  logic [SW-1:0] acc_mem [NBLK];
  logic [HW-1:0] hsum_q, hsum_d;
  logic [HW-1:0] h_sum;
  logic [SW-1:0] acc_sum;
  logic [SW-1:0] acc_wd;
  logic          acc_we;
  logic [JW-1:0] blk_j;
  logic          mode_d;

  assign blk_j    = JW'(col_q >> LOG2F);
  assign h_sum    = hsum_q + HW'(data);
  assign acc_sum  = acc_mem[blk_j] + SW'(h_sum);
  assign mode_d   = (valid && first_px) ? mode : mode_q;
  // The frame's first pixel already runs under the newly sampled mode.
  assign mode_eff = first_px ? mode : mode_q;

  always_comb begin
    hsum_d = hsum_q;
    acc_we = 1'b0;
    acc_wd = acc_sum;
    if (valid) begin
      hsum_d = (col_ph == '0) ? HW'(data) : h_sum;
      if (mode_eff && (col_ph == PH_LAST)) begin
        acc_we = 1'b1;
        acc_wd = (row_ph == '0) ? SW'(h_sum) : acc_sum;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsum_q <= '0;
      mode_q <= 1'b0;
    end else begin
      hsum_q <= hsum_d;
      mode_q <= mode_d;
    end
  end

  always_ff @(posedge clock) begin
    if (acc_we) acc_mem[blk_j] <= acc_wd;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_q      = 1'b0;
  assign mode_eff    = 1'b0;
`endif

  always_comb begin
    vld_p0_d = 1'b0;
    res_p0_d = res_p0_q;
    if (valid && !mode_eff && (col_ph == '0) && (row_ph == '0)) begin
      vld_p0_d = 1'b1;
      res_p0_d = data;
    end
`ifdef DOWNSAMPLER_AVG_EN
    if (valid && mode_eff && (col_ph == PH_LAST) && (row_ph == PH_LAST)) begin
      vld_p0_d = 1'b1;
      res_p0_d = avg_trunc(acc_sum);
    end
`endif
  end

  assign blankingregion = mode_q ? (row_ph != PH_LAST) : (row_ph != '0);

  // Stage p0: result registered on the edge that samples the pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      vld_p0_q <= vld_p0_d;
    end
  end

  always_ff @(posedge clock) begin
    res_p0_q <= res_p0_d;
    fs_p0_q  <= blk00;
  end

  // Stage p1: FIFO push of the p0 result
  logic [DATA_WIDTH:0]   fifo_mem [OUT_DEPTH];
  logic [AW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  pop, push;
  logic [DATA_WIDTH:0]   head;

  assign validout = (cnt_q != '0);
  assign pop      = validout && ready_out;
  assign push     = vld_p0_q && ((cnt_q != CNT_FULL) || pop);
  assign head     = fifo_mem[rd_q];

  always_comb begin
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    ovf_d = ovf_q | (vld_p0_q && !push);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_q] <= {fs_p0_q, res_p0_q};
  end

  assign dataout         = validout ? head[DATA_WIDTH-1:0] : '0;
  assign frame_start_out = validout && head[DATA_WIDTH];
  assign overflow        = ovf_q;
  assign fifo_count      = cnt_q;

endmodule

// File: tb/tb_downsampler_nx.sv
// Directed bench for downsampler_nx on 8x8 ramp frames (FACTOR 4 and 2, small FIFO).
module tb_downsampler_nx;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic       mode_f4, mode_f2, mode_bp;
  logic       rdy_f4, rdy_f2, rdy_bp;

  logic [7:0] dout_f4, dout_f2, dout_bp;
  logic       vout_f4, vout_f2, vout_bp;
  logic       fso_f4, fso_f2, fso_bp;
  logic       blank_f4, blank_f2, blank_bp;
  logic       ovf_f4, ovf_f2, ovf_bp;
  logic [4:0] cnt_f4, cnt_f2;
  logic [2:0] cnt_bp;

  int n_tests = 0;
  int n_fail  = 0;
  int q_f4[$], f_f4[$], q_f2[$], f_f2[$], q_bp[$];

  always #5 clock = ~clock;

  downsampler_nx #(.DATA_WIDTH(8), .FACTOR(4), .LINE_WIDTH(8), .FRAME_HEIGHT(8), .OUT_DEPTH(16)) u_f4 (
    .clock(clock), .reset(reset), .valid(valid), .data(data), .mode(mode_f4), .ready_out(rdy_f4),
    .dataout(dout_f4), .validout(vout_f4), .frame_start_out(fso_f4), .blankingregion(blank_f4),
    .overflow(ovf_f4), .fifo_count(cnt_f4));

  downsampler_nx #(.DATA_WIDTH(8), .FACTOR(2), .LINE_WIDTH(8), .FRAME_HEIGHT(8), .OUT_DEPTH(16)) u_f2 (
    .clock(clock), .reset(reset), .valid(valid), .data(data), .mode(mode_f2), .ready_out(rdy_f2),
    .dataout(dout_f2), .validout(vout_f2), .frame_start_out(fso_f2), .blankingregion(blank_f2),
    .overflow(ovf_f2), .fifo_count(cnt_f2));

  downsampler_nx #(.DATA_WIDTH(8), .FACTOR(2), .LINE_WIDTH(8), .FRAME_HEIGHT(8), .OUT_DEPTH(4)) u_bp (
    .clock(clock), .reset(reset), .valid(valid), .data(data), .mode(mode_bp), .ready_out(rdy_bp),
    .dataout(dout_bp), .validout(vout_bp), .frame_start_out(fso_bp), .blankingregion(blank_bp),
    .overflow(ovf_bp), .fifo_count(cnt_bp));

  // Record every pop (validout && ready_out) seen before the popping edge.
  always @(negedge clock) begin
    if (vout_f4 && rdy_f4) begin q_f4.push_back(int'(dout_f4)); f_f4.push_back(int'(fso_f4)); end
    if (vout_f2 && rdy_f2) begin q_f2.push_back(int'(dout_f2)); f_f2.push_back(int'(fso_f2)); end
    if (vout_bp && rdy_bp) q_bp.push_back(int'(dout_bp));
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input int q[$], input int e[$], input int n);
    check_val({tag, "_count"}, q.size(), n);
    foreach (e[i]) check_val($sformatf("%s_%0d", tag, i), (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      valid = 1'b0;
    end
  endtask

  // phase 1 adds first-output latency and backpressure checks.
  task automatic run_frame(input int npix, input bit avg_rule, input int phase);
    int r;
    int c;
    for (int k = 0; k < npix; k++) begin
      r = k / 8;
      c = k % 8;
      @(posedge clock); #1;
      if (c == 1)
        check_val($sformatf("blank_f4_p%0d_r%0d", phase, r), int'(blank_f4),
                  avg_rule ? int'((r % 4) != 3) : int'((r % 4) != 0));
      if (phase == 1 && k == 1) check_val("lat_vout_early", int'(vout_f4), 0);
      if (phase == 1 && k == 2) begin
        check_val("lat_vout", int'(vout_f4), 1);
        check_val("lat_dout", int'(dout_f4), 0);
        check_val("lat_fs",   int'(fso_f4), 1);
      end
      if (phase == 1 && k == 16) begin
        check_val("bp_cnt_full", int'(cnt_bp), 4);
        check_val("bp_ovf_before", int'(ovf_bp), 0);
      end
      if (phase == 1 && k == 18) check_val("bp_ovf_after", int'(ovf_bp), 1);
      valid = 1'b1;
      data  = 8'(r * 8 + c);
    end
    @(posedge clock); #1;
    valid = 1'b0;
  endtask

  int  e[$];
  bit  avg_en;

  initial begin
`ifdef DOWNSAMPLER_AVG_EN
    avg_en = 1'b1;
`else
    avg_en = 1'b0;
`endif
    reset = 1'b1; valid = 1'b0; data = '0;
    mode_f4 = 1'b0; mode_f2 = 1'b1; mode_bp = 1'b0;
    rdy_f4 = 1'b1; rdy_f2 = 1'b1; rdy_bp = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check_val("rst_vout",  int'(vout_f4), 0);
    check_val("rst_cnt",   int'(cnt_f4), 0);
    check_val("rst_ovf",   int'(ovf_f4), 0);
    check_val("rst_dout",  int'(dout_f4), 0);
    check_val("rst_fs",    int'(fso_f4), 0);
    check_val("rst_blank", int'(blank_f4), 0);

    // Frame 1: decimate FACTOR 4, FACTOR 2 with mode=1, FIFO depth 4 stalled.
    run_frame(64, 1'b0, 1);
    idle(6);
    e = '{0, 4, 32, 36};
    check_q("dec4", q_f4, e, 4);
    check_val("dec4_fs0", (f_f4.size() > 0) ? f_f4[0] : -1, 1);
    check_val("dec4_fs1", (f_f4.size() > 1) ? f_f4[1] : -1, 0);
    if (avg_en) e = '{4, 6, 8, 10, 20};
    else        e = '{0, 2, 4, 6, 16};
    check_q("f2", q_f2, e, 16);
    check_val("f2_fs0", (f_f2.size() > 0) ? f_f2[0] : -1, 1);
    check_val("f2_fs1", (f_f2.size() > 1) ? f_f2[1] : -1, 0);
    check_val("bp_cnt_end", int'(cnt_bp), 4);
    check_val("bp_ovf_end", int'(ovf_bp), 1);
    rdy_bp = 1'b1;
    idle(8);
    e = '{0, 2, 4, 6};
    check_q("bp_drain", q_bp, e, 4);
    check_val("bp_cnt_drained", int'(cnt_bp), 0);
    check_val("bp_ovf_sticky", int'(ovf_bp), 1);

    // Frame 2: FACTOR 4 with mode=1.
    q_f4.delete(); f_f4.delete();
    mode_f4 = 1'b1;
    run_frame(64, avg_en, 2);
    idle(6);
    if (avg_en) e = '{13, 17, 45, 49};
    else        e = '{0, 4, 32, 36};
    check_q("f4_m1", q_f4, e, 4);
    check_val("f4_m1_fs0", (f_f4.size() > 0) ? f_f4[0] : -1, 1);

    // Mid-frame reset with two results queued.
    q_f4.delete(); f_f4.delete();
    mode_f4 = 1'b0;
    rdy_f4  = 1'b0;
    run_frame(20, 1'b0, 3);
    idle(2);
    check_val("mid_cnt_before", int'(cnt_f4), 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check_val("mid_vout", int'(vout_f4), 0);
    check_val("mid_cnt",  int'(cnt_f4), 0);
    check_val("mid_ovf",  int'(ovf_f4), 0);
    check_val("mid_dout", int'(dout_f4), 0);
    rdy_f4 = 1'b1;
    q_f4.delete(); f_f4.delete();
    run_frame(64, 1'b0, 4);
    idle(6);
    e = '{0, 4, 32, 36};
    check_q("mid_redo", q_f4, e, 4);
    check_val("mid_redo_fs0", (f_f4.size() > 0) ? f_f4[0] : -1, 1);
    check_val("mid_redo_fs3", (f_f4.size() > 3) ? f_f4[3] : -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/downsampler_nx.md
Name: downsampler_nx

Overview:
- Parametrised successor to the fixed 4x downsampler. Reduces a raster pixel stream by FACTOR in both dimensions.
- Two reduction modes: decimation (keep the top-left pixel of each FACTOR x FACTOR block) or box average.
- Tags blanking rows and frame start, and buffers results in an internal single-clock FIFO with a ready/valid output.
- Sits between the camera capture front end and the feature-detection pipeline, in the capture clock domain.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- FACTOR, 4, reduction factor per axis. Legal values are 2, 4 and 8.
- LINE_WIDTH, 640, input pixels per line. Must be a multiple of FACTOR.
- FRAME_HEIGHT, 480, input lines per frame. Must be a multiple of FACTOR.
- OUT_DEPTH, 16, output FIFO depth. Must be a power of 2, at least 2.

Ports:
- clock, in, 1, the single clock.
- reset, in, 1, asynchronous, active-high reset.
- valid, in, 1, input pixel strobe. There is no input stall.
- data, in, DATA_WIDTH, input pixel.
- mode, in, 1, 0 = decimate, 1 = average. Sampled only at frame start.
- ready_out, in, 1, downstream ready.
- dataout, out, DATA_WIDTH, FIFO head pixel.
- validout, out, 1, FIFO non-empty.
- frame_start_out, out, 1, FIFO head is the first output pixel of a frame.
- blankingregion, out, 1, current input row produces no output.
- overflow, out, 1, sticky: a result was dropped.
- fifo_count, out, log2(OUT_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - col, row, hsum and mode_q cleared; FIFO emptied.
  - dataout=0, validout=0, frame_start_out=0, overflow=0, fifo_count=0, blankingregion=0.
  - Line-buffer contents are don't-care.
  - Reset mid-frame: the next valid pixel is treated as row 0, col 0.
- Counters:
  - col advances on valid and wraps at LINE_WIDTH-1.
  - On col wrap, row increments and wraps at FRAME_HEIGHT-1.
  - mode_q <= mode on a valid pixel at row 0, col 0. The current frame uses the new value.
- Decimate (mode_q=0): a result is produced on a valid pixel with col%FACTOR==0 and row%FACTOR==0. Result = data.
- Average (mode_q=1):
  - hsum: loaded with data at col%FACTOR==0, otherwise hsum+data.
  - At col%FACTOR==FACTOR-1, with h = completed horizontal sum and j = col/FACTOR:
    - row%FACTOR==0: acc[j] <= h.
    - otherwise: acc[j] <= acc[j]+h.
    - row%FACTOR==FACTOR-1: a result is produced, equal to (acc[j]+h) >> (2*log2(FACTOR)), truncated.
  - Line buffer is LINE_WIDTH/FACTOR entries of DATA_WIDTH+2*log2(FACTOR) bits; the width guarantees no overflow.
- Result tagging: frame_start is stored with the result when the result is for output block (0,0).
- Latency:
  - The result is registered on the edge that samples the pixel, and pushed into the FIFO on the next edge.
  - If the FIFO was empty, validout rises after that push edge: 2 cycles pixel-to-validout.
- FIFO:
  - First-word fall-through; dataout and frame_start_out are valid whenever validout=1.
  - Pop when validout && ready_out.
  - A push is accepted if fifo_count<OUT_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the result is dropped and overflow is set. overflow stays high until reset.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Read pointer and write pointer wrap modulo OUT_DEPTH.
- blankingregion: combinational decode of the registered row counter and mode_q.
  - mode_q=0: 1 when row%FACTOR!=0.
  - mode_q=1: 1 when row%FACTOR!=FACTOR-1.

Optional Feature:
- Macro: DOWNSAMPLER_AVG_EN.
- Defined: average mode and its line buffer are compiled in.
- Undefined:
  - No line buffer or hsum logic.
  - mode is ignored and mode_q is forced to 0; the block always decimates.
  - blankingregion uses the decimate rule.

Test Plan:
- Decimate, FACTOR=4, 8x8 frame, data=row*8+col, ready_out=1 -> outputs 0,4,32,36. frame_start_out=1 only with 0. First validout 2 cycles after pixel 0.
- Average (macro defined), FACTOR=2, same ramp, mode=1 -> first output row 4,6,8,10. Second output row starts with 20. frame_start_out=1 with 4.
- Backpressure: OUT_DEPTH=4, decimate FACTOR=2, 8x8 frame, ready_out=0 -> fifo_count=4 and overflow=1 after the 5th result. Raising ready_out then drains 0,2,4,6. overflow stays 1.
- Blanking: decimate FACTOR=4, 8x8 frame -> blankingregion=0 on rows 0 and 4, 1 on rows 1-3 and 5-7. In average mode, 0 only on rows 3 and 7.
- Reset mid-frame: after 20 pixels with 2 results queued, pulse reset -> validout=0, fifo_count=0, overflow=0. A following full frame reproduces the scenario-1 outputs exactly.
- Macro undefined, mode=1, FACTOR=4 ramp -> outputs 0,4,32,36 (decimation).
